instr_fetch_unit: RTL

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/cpu_pkg.sv | 16 +
 rtl/instr_fetch_unit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch unit and the downstream controller:
// fetch FSM encodings, IM base offset and the halt instruction word.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_VALID   = 3'd3,
    ST_DONE    = 3'd4
  } fetch_state_e;

  localparam int unsigned IM_START  = 32'h7F;
  localparam int unsigned HALT_WORD = 32'h0;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: walks the program in IM one instruction at a time,
// handing each to the controller and waiting for it to retire.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int          MemSize    = 10,
  parameter int          DataSize   = 32,
  parameter int          IMAddrSize = 10,
  parameter int unsigned IMStart    = IM_START
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [15:0]           total_ir,
  input  logic                  ins_done,
  input  logic [DataSize-1:0]   im_dout,
  output logic                  im_enable,
  output logic                  im_fetch,
  output logic                  im_write,
  output logic [IMAddrSize-1:0] im_address,
  output logic [MemSize-1:0]    PC,
  output logic [DataSize-1:0]   ir,
  output logic                  ir_valid,
  output logic [15:0]           fetch_cnt,
  output logic                  prog_done
);

  fetch_state_e       state;
  logic [MemSize-1:0] next_pc;
  logic [15:0]        total_q;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [IMAddrSize-1:0] im_addr_of(input logic [MemSize-1:0] pc);
    logic [31:0] sum;
    sum = 32'(pc) + IMStart;
    return sum[IMAddrSize-1:0];
  endfunction

  assign im_write = 1'b0;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      next_pc    <= '0;
      total_q    <= '0;
      PC         <= '0;
      ir         <= '0;
      ir_valid   <= 1'b0;
      im_enable  <= 1'b0;
      im_fetch   <= 1'b0;
      im_address <= '0;
      fetch_cnt  <= '0;
      prog_done  <= 1'b0;
    end else begin
      // IM strobes are single-cycle: only a transition into FETCH raises them
      im_enable  <= 1'b0;
      im_fetch   <= 1'b0;
      im_address <= '0;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            total_q   <= total_ir;
            PC        <= '0;
            ir        <= '0;
            ir_valid  <= 1'b0;
            fetch_cnt <= '0;
            if (total_ir == 16'd0) begin
              state     <= ST_DONE;
              prog_done <= 1'b1;
            end else begin
              state      <= ST_FETCH;
              prog_done  <= 1'b0;
              next_pc    <= MemSize'(1);
              im_enable  <= 1'b1;
              im_fetch   <= 1'b1;
              im_address <= im_addr_of(MemSize'(1));
            end
          end
        end
        ST_FETCH: begin
          state <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (im_dout == DataSize'(HALT_WORD)) begin
            PC        <= '0;
            ir        <= '0;
            prog_done <= 1'b1;
            state     <= ST_DONE;
          end else begin
            ir        <= im_dout;
            PC        <= next_pc;
            fetch_cnt <= sat_inc16(fetch_cnt);
            next_pc   <= next_pc + MemSize'(1);
            ir_valid  <= 1'b1;
            state     <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (ins_done) begin
            ir_valid <= 1'b0;
            if (fetch_cnt >= total_q) begin
              prog_done <= 1'b1;
              state     <= ST_DONE;
            end else begin
              im_enable  <= 1'b1;
              im_fetch   <= 1'b1;
              im_address <= im_addr_of(next_pc);
              state      <= ST_FETCH;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
